// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation encoding and
// the helper that says which operations advance the word counter.
package usr_pkg;

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        SHL   = 3'd1,
        SHR   = 3'd2,
        ROL   = 3'd3,
        ROR   = 3'd4,
        LOAD  = 3'd5,
        CLEAR = 3'd6,
        RSVD  = 3'd7
    } mode_e;

    function automatic logic is_shift(input mode_e m);
        return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR);
    endfunction

endpackage

// File: rtl/shift_frame_cnt.sv
// Word counter for the shift register: counts shifts modulo WIDTH and emits a
// one-cycle frame pulse on the edge that completes a word.
module shift_frame_cnt #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             shift_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             frame_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             frame_d, frame_q;

    // frame defaults low so it is a single-cycle pulse regardless of en_i.
    always_comb begin
        cnt_d   = cnt_q;
        frame_d = 1'b0;
        if (en_i) begin
            if (clr_i) begin
                cnt_d = '0;
            end else if (shift_i) begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    frame_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
        end
    end

    assign cnt_o   = cnt_q;
    assign frame_o = frame_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift/rotate left/right, parallel load and
// clear, with a word counter that marks each completed WIDTH-shift word.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter  int               WIDTH     = 8,
    parameter  logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int               CNT_W     = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [2:0]       mode_i,
    input  logic             sin_l_i,
    input  logic             sin_r_i,
    input  logic [WIDTH-1:0] load_i,
    output logic [WIDTH-1:0] sr_o,
    output logic             sout_l_o,
    output logic             sout_r_o,
    output logic [CNT_W-1:0] cnt_o,
    output logic             frame_o
);

    mode_e            mode;
    logic [WIDTH-1:0] sr_d, sr_q;
    logic             shift;
    logic             clr;

    always_comb begin
        mode  = mode_e'(mode_i);
        sr_d  = sr_q;
        shift = is_shift(mode);
        clr   = (mode == LOAD) || (mode == CLEAR);
        if (en_i) begin
            case (mode)
                SHL:     sr_d = {sr_q[WIDTH-2:0], sin_l_i};
                SHR:     sr_d = {sin_r_i, sr_q[WIDTH-1:1]};
                ROL:     sr_d = {sr_q[WIDTH-2:0], sr_q[WIDTH-1]};
                ROR:     sr_d = {sr_q[0], sr_q[WIDTH-1:1]};
                LOAD:    sr_d = load_i;
                CLEAR:   sr_d = RESET_VAL;
                default: sr_d = sr_q;  // HOLD and the reserved code
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q <= RESET_VAL;
        end else begin
            sr_q <= sr_d;
        end
    end

    shift_frame_cnt #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (en_i),
        .shift_i (shift),
        .clr_i   (clr),
        .cnt_o   (cnt_o),
        .frame_o (frame_o)
    );

    assign sr_o     = sr_q;
    assign sout_l_o = sr_q[WIDTH-1];
    assign sout_r_o = sr_q[0];

endmodule
